rank_select_pipe: RTL and testbench

Pipelined, parametrised rank-order selector for a CHANNELS-wide sample vector: each accepted vector returns the element of a run-time-selected rank (min, median, max or any order statistic) plus the channel it came from. Ties are resolved deterministically, so exactly one channel always holds each rank. The block sits in the sample path after channel capture, in place of the fixed 8-channel median stage, with valid/ready flow control on both sides.

---
 rtl/rank_select_pipe.sv | 219 +++++++++++++++++++++
 tb/tb_rank_select_pipe.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rank_select_pipe.sv
// ---------------------------------------------------------------------------
// rank_select_pipe
//
// Three-stage pipelined order-statistic selector. Each accepted vector of
// CHANNELS samples returns the sample holding the requested rank (0 = minimum)
// and the channel it came from. Equal samples are ordered by channel index,
// so every rank is owned by exactly one channel.
//
// Parameters
//   CHANNELS  number of input channels (>= 2)
//   WIDTH     bits per channel sample
//   SIGNED    1 = two's-complement compare, 0 = unsigned compare
//   IDX_W     width of rank / index fields, $clog2(CHANNELS)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   data_in / rank_in valid
//   in_ready   block accepts a vector this cycle
//   data_in    packed samples, channel 0 in the LSBs
//   rank_in    requested rank
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   data_out   selected sample
//   index_out  channel index of the selected sample
//
// Pipeline
//   S1  register samples and the (saturated) requested rank
//   S2  pairwise compares -> per-channel rank, registered
//   S3  pick the channel whose rank matches the request, registered
// All stages share one enable, so the pipeline stalls as a single unit.
// ---------------------------------------------------------------------------
module rank_select_pipe #(
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 8,
    parameter int SIGNED   = 0,
    parameter int IDX_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [IDX_W-1:0]          rank_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          data_out,
    output logic [IDX_W-1:0]          index_out
);

    // Number of unordered channel pairs; one comparator per pair.
    localparam int NPAIR = CHANNELS * (CHANNELS - 1) / 2;

    // Flat index of pair (a, b) with a < b, enumerated row by row.
    function automatic int pair_idx(input int a, input int b);
        return a * CHANNELS - (a * (a + 1)) / 2 + (b - a - 1);
    endfunction

    // Sample compare a <= b in the configured number format.
    function automatic logic le_val(input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b);
        if (SIGNED != 0) begin
            return $signed(a) <= $signed(b);
        end else begin
            return a <= b;
        end
    endfunction

    genvar gi, gj;

    // -----------------------------------------------------------------------
    // Flow control: a single enable moves every stage, bubbles included.
    // -----------------------------------------------------------------------
    logic en;
    logic out_valid_reg;

    assign en       = !out_valid_reg || out_ready;
    assign in_ready = en && !rst;

    // -----------------------------------------------------------------------
    // S1: capture samples and requested rank
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] in_chan     [CHANNELS];
    logic [WIDTH-1:0] s1_data_reg [CHANNELS];
    logic [IDX_W-1:0] rank_sat;
    logic [IDX_W-1:0] s1_rank_reg;
    logic             s1_valid_reg;

    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_unpack
            assign in_chan[gi] = data_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // For non-power-of-two CHANNELS the rank field can encode values past
    // the last channel; those requests mean "maximum".
    always_comb begin
        rank_sat = rank_in;
        if ({1'b0, rank_in} > (IDX_W+1)'(CHANNELS - 1)) begin
            rank_sat = IDX_W'(CHANNELS - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
        end else if (en) begin
            s1_valid_reg <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s1_data_reg <= in_chan;
            s1_rank_reg <= rank_sat;
        end
    end

    // -----------------------------------------------------------------------
    // S2: pairwise compares and per-channel rank
    // -----------------------------------------------------------------------
    // pair_le[pair_idx(a,b)] = 1 means sample a <= sample b (a < b). Because
    // the lower index wins ties, that bit alone says "a precedes b", and its
    // complement says "b precedes a".
    logic [NPAIR-1:0] pair_le;

    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_row
            for (gj = gi + 1; gj < CHANNELS; gj++) begin : g_col
                localparam int PI = pair_idx(gi, gj);
                assign pair_le[PI] = le_val(s1_data_reg[gi], s1_data_reg[gj]);
            end
        end
    endgenerate

    // Rank of channel k = number of channels that precede it.
    logic [IDX_W-1:0] rank_cnt [CHANNELS];

    always_comb begin
        logic [IDX_W-1:0] acc;
        rank_cnt = '{default: '0};
        acc      = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            acc = '0;
            for (int j = 0; j < CHANNELS; j++) begin
                if (j < k) begin
                    acc = acc + IDX_W'(pair_le[pair_idx(j, k)]);
                end else if (j > k) begin
                    acc = acc + IDX_W'(!pair_le[pair_idx(k, j)]);
                end
            end
            rank_cnt[k] = acc;
        end
    end

    logic [WIDTH-1:0] s2_data_reg [CHANNELS];
    logic [IDX_W-1:0] s2_pos_reg  [CHANNELS];
    logic [IDX_W-1:0] s2_rank_reg;
    logic             s2_valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
        end else if (en) begin
            s2_valid_reg <= s1_valid_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s2_data_reg <= s1_data_reg;
            s2_pos_reg  <= rank_cnt;
            s2_rank_reg <= s1_rank_reg;
        end
    end

    // -----------------------------------------------------------------------
    // S3: select the unique channel holding the requested rank
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] sel_data;
    logic [IDX_W-1:0] sel_idx;

    // Channel ranks form a permutation, so at most one k matches and the
    // loop order does not act as a priority.
    always_comb begin
        sel_data = '0;
        sel_idx  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (s2_pos_reg[k] == s2_rank_reg) begin
                sel_data = s2_data_reg[k];
                sel_idx  = IDX_W'(k);
            end
        end
    end

    logic [WIDTH-1:0] data_out_reg;
    logic [IDX_W-1:0] index_out_reg;

    // Result registers load only for real vectors, so they stay stable
    // across bubbles and stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            data_out_reg  <= '0;
            index_out_reg <= '0;
        end else if (en) begin
            out_valid_reg <= s2_valid_reg;
            if (s2_valid_reg) begin
                data_out_reg  <= sel_data;
                index_out_reg <= sel_idx;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign data_out  = data_out_reg;
    assign index_out = index_out_reg;

endmodule

// File: tb/tb_rank_select_pipe.sv
// ---------------------------------------------------------------------------
// tb_rank_select_pipe
//
// Drives three instances from one stimulus stream: 8 channels unsigned,
// 8 channels signed, and 5 channels unsigned (fed the low five channels).
// A sort-based reference picks the expected order statistic for each
// accepted vector; a negedge compare process checks every valid output.
// Directed sequences add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_rank_select_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] data_in;
    logic [2:0]  rank_in;

    logic       in_ready_u8, in_ready_s8, in_ready_u5;
    logic       out_valid_u8, out_valid_s8, out_valid_u5;
    logic [7:0] data_out_u8, data_out_s8, data_out_u5;
    logic [2:0] index_out_u8, index_out_s8, index_out_u5;

    rank_select_pipe #(.CHANNELS(8), .WIDTH(8), .SIGNED(0)) u_dut_u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u8),
        .data_in(data_in), .rank_in(rank_in), .out_valid(out_valid_u8),
        .out_ready(out_ready), .data_out(data_out_u8), .index_out(index_out_u8));

    rank_select_pipe #(.CHANNELS(8), .WIDTH(8), .SIGNED(1)) u_dut_s8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s8),
        .data_in(data_in), .rank_in(rank_in), .out_valid(out_valid_s8),
        .out_ready(out_ready), .data_out(data_out_s8), .index_out(index_out_s8));

    rank_select_pipe #(.CHANNELS(5), .WIDTH(8), .SIGNED(0)) u_dut_u5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u5),
        .data_in(data_in[39:0]), .rank_in(rank_in), .out_valid(out_valid_u5),
        .out_ready(out_ready), .data_out(data_out_u5), .index_out(index_out_u5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int d;
        int i;
    } exp_t;

    exp_t q_u8[$];
    exp_t q_s8[$];
    exp_t q_u5[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: sort (value, channel) keys and take the r-th entry.
    // Signed values are biased by 128 so integer order matches.
    function automatic void ref_sel(input logic [63:0] d, input int ch,
                                    input bit sgn, input int r,
                                    output int vd, output int vi);
        int keys[$];
        int v;
        int rr;
        for (int c = 0; c < ch; c++) begin
            v = int'(d[c*8 +: 8]);
            if (sgn) v = v ^ 128;
            keys.push_back(v * 16 + c);
        end
        keys.sort();
        rr = (r > ch - 1) ? ch - 1 : r;
        vi = keys[rr] % 16;
        vd = (keys[rr] / 16) ^ (sgn ? 128 : 0);
    endfunction

    task automatic cmp_port(input string nm, input logic ov, input int dv,
                            input int iv, ref exp_t q[$]);
        if (ov) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_spurious: got out_valid=1 expected no pending result", nm);
            end else begin
                chk({nm, "_data"}, dv, q[0].d);
                chk({nm, "_index"}, iv, q[0].i);
                if (out_ready) void'(q.pop_front());
            end
        end
    endtask

    bit stall_prev = 0;
    int held_u8 = 0;
    int held_s8 = 0;
    int held_u5 = 0;

    // Per-cycle compare. Inputs change only just after posedge, so the
    // values seen here are the ones the next edge will act on.
    always @(negedge clk) begin
        int vd, vi;
        if (rst) begin
            q_u8.delete();
            q_s8.delete();
            q_u5.delete();
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                chk("stall_hold_u8", int'(data_out_u8), held_u8);
                chk("stall_hold_s8", int'(data_out_s8), held_s8);
                chk("stall_hold_u5", int'(data_out_u5), held_u5);
            end
            if (out_valid_u8 && !out_ready) begin
                chk("in_ready_stall", int'(in_ready_u8), 0);
            end else begin
                chk("in_ready_open", int'(in_ready_u8), 1);
            end
            cmp_port("u8", out_valid_u8, int'(data_out_u8), int'(index_out_u8), q_u8);
            cmp_port("s8", out_valid_s8, int'(data_out_s8), int'(index_out_s8), q_s8);
            cmp_port("u5", out_valid_u5, int'(data_out_u5), int'(index_out_u5), q_u5);
            stall_prev = out_valid_u8 && !out_ready;
            held_u8 = int'(data_out_u8);
            held_s8 = int'(data_out_s8);
            held_u5 = int'(data_out_u5);
            if (in_valid && in_ready_u8) begin
                ref_sel(data_in, 8, 1'b0, int'(rank_in), vd, vi);
                q_u8.push_back('{d: vd, i: vi});
                ref_sel(data_in, 8, 1'b1, int'(rank_in), vd, vi);
                q_s8.push_back('{d: vd, i: vi});
                ref_sel({24'd0, data_in[39:0]}, 5, 1'b0, int'(rank_in), vd, vi);
                q_u5.push_back('{d: vd, i: vi});
            end
        end
    end

    function automatic logic [63:0] pk(input int c [8]);
        logic [63:0] v;
        for (int k = 0; k < 8; k++) v[k*8 +: 8] = c[k][7:0];
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_vec();
        bit tie_mode;
        tie_mode = ($urandom_range(0, 1) == 1);
        for (int c = 0; c < 8; c++) begin
            data_in[c*8 +: 8] = tie_mode ? 8'($urandom_range(0, 3))
                                         : 8'($urandom_range(0, 255));
        end
        rank_in = 3'($urandom_range(0, 7));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  sent;
        int  cyc;
        bit  xfer;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data_in   = '0;
        rank_in   = '0;

        // Reset then idle
        step();
        chk("rst_out_valid", int'(out_valid_u8), 0);
        chk("rst_data_out", int'(data_out_u8), 0);
        chk("rst_index_out", int'(index_out_u8), 0);
        chk("rst_in_ready", int'(in_ready_u8), 0);
        step();
        chk("rst_in_ready2", int'(in_ready_u5), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(in_ready_u8), 1);
        step();
        chk("idle_out_valid", int'(out_valid_u8), 0);

        // Distinct values, ranks 0/3/7 back to back
        in_valid = 1'b1;
        data_in  = pk('{9, 3, 7, 1, 8, 2, 6, 5});
        rank_in  = 3'd0;
        step();
        chk("lat_edge0_valid", int'(out_valid_u8), 0);
        rank_in = 3'd3;
        step();
        chk("lat_edge1_valid", int'(out_valid_u8), 0);
        rank_in = 3'd7;
        step();
        in_valid = 1'b0;
        chk("dist_r0_valid", int'(out_valid_u8), 1);
        chk("dist_r0_data", int'(data_out_u8), 1);
        chk("dist_r0_index", int'(index_out_u8), 3);
        step();
        chk("dist_r3_data", int'(data_out_u8), 5);
        chk("dist_r3_index", int'(index_out_u8), 7);
        chk("dist_r3_u5_data", int'(data_out_u5), 8);
        chk("dist_r3_u5_index", int'(index_out_u5), 4);
        step();
        chk("dist_r7_data", int'(data_out_u8), 9);
        chk("dist_r7_index", int'(index_out_u8), 0);
        step();
        chk("dist_drained", int'(out_valid_u8), 0);

        // Ties
        in_valid = 1'b1;
        data_in  = pk('{8'h44, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44});
        rank_in  = 3'd4;
        step();
        data_in  = pk('{5, 5, 2, 2, 5, 2, 5, 5});
        rank_in  = 3'd3;
        step();
        in_valid = 1'b0;
        step();
        chk("tie_all_data", int'(data_out_u8), 8'h44);
        chk("tie_all_index", int'(index_out_u8), 4);
        step();
        chk("tie_mix_data", int'(data_out_u8), 5);
        chk("tie_mix_index", int'(index_out_u8), 0);

        // Signed versus unsigned compare
        in_valid = 1'b1;
        data_in  = pk('{8'h80, 8'h7F, 8'h00, 8'hFF, 8'h10, 8'h20, 8'h30, 8'h40});
        rank_in  = 3'd0;
        step();
        rank_in  = 3'd7;
        step();
        in_valid = 1'b0;
        step();
        chk("sgn_min_s8_data", int'(data_out_s8), 8'h80);
        chk("sgn_min_s8_index", int'(index_out_s8), 0);
        chk("sgn_min_u8_data", int'(data_out_u8), 8'h00);
        chk("sgn_min_u8_index", int'(index_out_u8), 2);
        step();
        chk("sgn_max_s8_data", int'(data_out_s8), 8'h7F);
        chk("sgn_max_u8_data", int'(data_out_u8), 8'hFF);

        // Rank saturation on the 5-channel instance
        in_valid = 1'b1;
        data_in  = pk('{3, 9, 4, 1, 7, 0, 0, 0});
        rank_in  = 3'd7;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("sat_u5_data", int'(data_out_u5), 9);
        chk("sat_u5_index", int'(index_out_u5), 1);

        // Reset with three vectors in flight
        in_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            rand_vec();
            step();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        chk("midrst_out_valid", int'(out_valid_u8), 0);
        chk("midrst_in_ready", int'(in_ready_u8), 0);
        step();
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step();
            chk("midrst_flushed", int'(out_valid_u8), 0);
        end
        in_valid = 1'b1;
        data_in  = pk('{10, 20, 30, 40, 50, 60, 70, 80});
        rank_in  = 3'd5;
        step();
        in_valid = 1'b0;
        chk("after_rst_lat0", int'(out_valid_u8), 0);
        step();
        chk("after_rst_lat1", int'(out_valid_u8), 0);
        step();
        chk("after_rst_valid", int'(out_valid_u8), 1);
        chk("after_rst_data", int'(data_out_u8), 60);
        chk("after_rst_index", int'(index_out_u8), 5);
        chk("after_rst_u5_data", int'(data_out_u5), 50);
        step();

        // Random stream with random backpressure
        in_valid = 1'b0;
        sent = 0;
        cyc  = 0;
        while (sent < 200 && cyc < 5000) begin
            @(negedge clk);
            xfer = in_valid && in_ready_u8;
            @(posedge clk);
            #1;
            cyc++;
            if (xfer) sent++;
            if (xfer || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                rand_vec();
            end
            out_ready = ($urandom_range(0, 1) == 1);
        end
        chk("stream_sent", sent, 200);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 10; n++) step();
        chk("drain_u8", q_u8.size(), 0);
        chk("drain_s8", q_s8.size(), 0);
        chk("drain_u5", q_u5.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
